// File: rtl/note_recorder_pkg.sv
// note_recorder_pkg: shared state, width and entry definitions for the note recorder
package note_recorder_pkg;
  localparam int NOTE_W = 4;
  localparam int OCT_W = 2;
  typedef enum logic [1:0] {IDLE, RECORD, PLAY, GAP} state_t;
  typedef struct packed {
    logic [OCT_W-1:0]  octave;
    logic [NOTE_W-1:0] note;
  } entry_t;
endpackage

// File: rtl/note_timer.sv
// note_timer: loadable down-counter; load/value start a run of value cycles, done pulses in the last one
module note_timer #(
  parameter int MAX_TICKS = 25_000_000,
  localparam int TW = $clog2(MAX_TICKS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] value,
  output logic          done
);
  logic [TW-1:0] cnt;
  logic          armed;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= value - 1'b1;
      armed <= 1'b1;
    end else if (armed && cnt == '0) begin
      armed <= 1'b0;
    end else if (armed) begin
      cnt <= cnt - 1'b1;
    end
  end
  assign done = armed && cnt == '0;
endmodule

// File: rtl/note_recorder.sv
// note_recorder: records live note events and replays them at a fixed tempo (loop replay with NOTE_RECORDER_LOOP_EN)
// ports: clk, reset (sync, active-high); live note_in/octave_in/note_valid; controls record_en, play_start,
//        play_stop, clear; outputs note_out/octave_out/note_out_valid to the datapath, playing, count, full
module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int NOTE_TICKS = 25_000_000,
  parameter int GAP_TICKS = 2_500_000,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [OCT_W-1:0]  octave_in,
  input  logic              note_valid,
  input  logic              record_en,
  input  logic              play_start,
  input  logic              play_stop,
  input  logic              clear,
  output logic [NOTE_W-1:0] note_out,
  output logic [OCT_W-1:0]  octave_out,
  output logic              note_out_valid,
  output logic              playing,
  output logic [CW-1:0]     count,
  output logic              full
);
  localparam int IW = $clog2(DEPTH);
  localparam int MAX_T = NOTE_TICKS > GAP_TICKS ? NOTE_TICKS : GAP_TICKS;
  localparam int TW = $clog2(MAX_T + 1);
  state_t        state;
  entry_t        mem [DEPTH];
  logic [IW-1:0] idx, nidx;
  logic          done, start, to_gap, more, next_note, tmr_load, wr;
  logic [TW-1:0] tmr_value;
  assign full = count == CW'(DEPTH);
  assign playing = state == PLAY || state == GAP;
  always_comb begin
    start = state == IDLE && !record_en && play_start && count != '0;
    to_gap = state == PLAY && done && !play_stop;
    more = CW'(idx) + 1'b1 < count;
    nidx = more ? idx + 1'b1 : '0;
`ifdef NOTE_RECORDER_LOOP_EN
    next_note = state == GAP && done && !play_stop;
`else
    next_note = state == GAP && done && !play_stop && more;
`endif
    tmr_load = start || to_gap || next_note;
    tmr_value = to_gap ? TW'(GAP_TICKS) : TW'(NOTE_TICKS);
    wr = !reset && state == RECORD && note_valid && !full;
  end
  note_timer #(.MAX_TICKS(MAX_T)) u_timer (
    .clk  (clk),
    .rst  (reset),
    .load (tmr_load),
    .value(tmr_value),
    .done (done)
  );
  always_ff @(posedge clk) begin
    if (wr) mem[count[IW-1:0]] <= {octave_in, note_in};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      idx            <= '0;
      note_out       <= '0;
      octave_out     <= '0;
      note_out_valid <= 1'b0;
    end else if (playing && play_stop) begin
      state          <= IDLE;
      note_out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          {octave_out, note_out, note_out_valid} <= {octave_in, note_in, note_valid};
          if (record_en) begin
            state <= RECORD;
            count <= '0;
          end else if (start) begin
            state                  <= PLAY;
            idx                    <= '0;
            {octave_out, note_out} <= mem[0];
            note_out_valid         <= 1'b1;
          end else if (clear) begin
            count <= '0;
          end
        end
        RECORD: begin
          {octave_out, note_out, note_out_valid} <= {octave_in, note_in, note_valid};
          if (wr) count <= count + 1'b1;
          if (!record_en) state <= IDLE;
        end
        PLAY: begin
          if (to_gap) begin
            state          <= GAP;
            note_out_valid <= 1'b0;
          end
        end
        GAP: begin
          if (next_note) begin
            state                  <= PLAY;
            idx                    <= nidx;
            {octave_out, note_out} <= mem[nidx];
            note_out_valid         <= 1'b1;
          end else if (done) begin
            state                                  <= IDLE;
            {octave_out, note_out, note_out_valid} <= {octave_in, note_in, note_valid};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
